// File: rtl/master_address_transmitter_if.sv
// Bus bundle between the I2C master controller and the address transmitter.
// The slave modport is the transmitter's view; master is the controller's view.
interface master_address_transmitter_if;
  logic       enable;
  logic [6:0] I2C_addr;
  logic       rw;
  logic       SCL;
  logic       SCL_prev;
  logic       SDA;
  logic       sda_drive_low;
  logic       busy;
  logic       done;
  logic       ack;
  logic       arb_lost;
  logic [3:0] bit_count;

  modport master (
    output enable, I2C_addr, rw, SCL, SCL_prev, SDA,
    input  sda_drive_low, busy, done, ack, arb_lost, bit_count
  );

  modport slave (
    input  enable, I2C_addr, rw, SCL, SCL_prev, SDA,
    output sda_drive_low, busy, done, ack, arb_lost, bit_count
  );
endinterface

// File: rtl/master_address_transmitter.sv
// I2C master address phase: shifts {addr, rw} out MSB first as open-drain
// pull-low requests, samples the slave ACK, and flags multi-master arbitration loss.
module master_address_transmitter #(
  parameter bit ARB_CHECK_EN = 1'b1
) (
  input  logic                          FPGA_clk,
  input  logic                          rst,
  master_address_transmitter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, ACK, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] shreg, shreg_n;
  logic       sda_q, sda_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       ack_q, ack_n;
  logic       arb_q, arb_n;
  logic [3:0] cnt_q, cnt_n;
  logic       rise, fall;

  assign rise = bus.SCL & ~bus.SCL_prev;
  assign fall = ~bus.SCL & bus.SCL_prev;

  always_ff @(posedge FPGA_clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state  <= IDLE;
      sda_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
      arb_q  <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      state  <= state_n;
      sda_q  <= sda_n;
      busy_q <= busy_n;
      done_q <= done_n;
      ack_q  <= ack_n;
      arb_q  <= arb_n;
      cnt_q  <= cnt_n;
    end
  end

  // NOTE: the shift register is left out of reset; it is reloaded on every accepted enable.
  always_ff @(posedge FPGA_clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_n = state;
    shreg_n = shreg;
    sda_n   = sda_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    ack_n   = ack_q;
    arb_n   = arb_q;
    cnt_n   = cnt_q;

    case (state)
      IDLE: begin
        // SCL edges coinciding with enable are deliberately ignored.
        if (bus.enable) begin
          shreg_n = {bus.I2C_addr, bus.rw};
          ack_n   = 1'b0;
          arb_n   = 1'b0;
          cnt_n   = 4'd0;
          busy_n  = 1'b1;
          sda_n   = ~bus.I2C_addr[6];
          state_n = SHIFT;
        end
      end

      SHIFT: begin
        if (rise) begin
          // A released bit read back as low means another master won the bus.
          if (ARB_CHECK_EN && shreg[7] && !bus.SDA) begin
            arb_n   = 1'b1;
            sda_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        end else if (fall) begin
          cnt_n = cnt_q + 4'd1;
          if (cnt_n < 4'd8) begin
            shreg_n = {shreg[6:0], 1'b0};
            sda_n   = ~shreg[6];
          end else begin
            sda_n   = 1'b0;
            state_n = ACK;
          end
        end
      end

      ACK: begin
        if (rise) begin
          ack_n   = ~bus.SDA;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // done is raised on the transition into DONE so the pulse coincides with that state.
  assign bus.sda_drive_low = sda_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.ack           = ack_q;
  assign bus.arb_lost      = arb_q;
  assign bus.bit_count     = cnt_q;

endmodule

// File: tb/tb_master_address_transmitter.sv
// Directed bench for master_address_transmitter: two instances (arbitration check
// on and off) share one SCL/enable stimulus; each sees its own wired-AND SDA.
module tb_master_address_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] addr = 7'h00;
  logic       rw = 1'b0;
  logic       scl = 1'b0;
  logic       scl_prev = 1'b0;
  logic       pull_low = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_a   = 0;
  int done_b   = 0;
  logic [7:0] seen_a, seen_b;

  master_address_transmitter_if bus_a ();
  master_address_transmitter_if bus_b ();

  assign bus_a.enable   = enable;
  assign bus_a.I2C_addr = addr;
  assign bus_a.rw       = rw;
  assign bus_a.SCL      = scl;
  assign bus_a.SCL_prev = scl_prev;
  assign bus_a.SDA      = ~(bus_a.sda_drive_low | pull_low);
  assign bus_b.enable   = enable;
  assign bus_b.I2C_addr = addr;
  assign bus_b.rw       = rw;
  assign bus_b.SCL      = scl;
  assign bus_b.SCL_prev = scl_prev;
  assign bus_b.SDA      = ~(bus_b.sda_drive_low | pull_low);

  master_address_transmitter #(.ARB_CHECK_EN(1'b1)) dut_a (
    .FPGA_clk (clk),
    .rst      (rst),
    .bus      (bus_a.slave)
  );

  master_address_transmitter #(.ARB_CHECK_EN(1'b0)) dut_b (
    .FPGA_clk (clk),
    .rst      (rst),
    .bus      (bus_b.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    scl_prev <= scl;
    if (bus_a.done) done_a <= done_a + 1;
    if (bus_b.done) done_b <= done_b + 1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start(input logic [6:0] a, input logic r);
    addr   = a;
    rw     = r;
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  // Clocks bits [from, to) and records the level each DUT requested before each rise.
  task automatic send_bits(input int from, input int to, input int pull_at);
    for (int i = from; i < to; i++) begin
      seen_a[7-i] = bus_a.sda_drive_low;
      seen_b[7-i] = bus_b.sda_drive_low;
      pull_low = (i == pull_at);
      scl = 1'b1;
      tick();
      pull_low = 1'b0;
      tick();
      scl = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic finish_ack;
    tick();
    pull_low = 1'b0;
    scl = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus_a.sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL reset_sda: got %b want 0", bus_a.sda_drive_low); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
    n_checks++; if ({bus_a.ack, bus_a.arb_lost} !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b want 00", {bus_a.ack, bus_a.arb_lost}); end
    n_checks++; if (bus_a.bit_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus_a.bit_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ack_0x50;
    int d0;
    start(7'h50, 1'b0);
    n_checks++; if (bus_a.sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL ack50_first_bit: got %b want 0", bus_a.sda_drive_low); end
    n_checks++; if (bus_a.busy !== 1'b1) begin n_fail++; $display("FAIL ack50_busy: got %b want 1", bus_a.busy); end
    send_bits(0, 8, -1);
    n_checks++; if (seen_a !== 8'b01011111) begin n_fail++; $display("FAIL ack50_pattern: got %b want 01011111", seen_a); end
    n_checks++; if (bus_a.sda_drive_low !== 1'b0) begin n_fail++; $display("FAIL ack50_release: got %b want 0", bus_a.sda_drive_low); end
    n_checks++; if (bus_a.bit_count !== 4'd8) begin n_fail++; $display("FAIL ack50_count: got %0d want 8", bus_a.bit_count); end
    d0 = done_a;
    pull_low = 1'b1;
    scl = 1'b1;
    tick();
    n_checks++; if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL ack50_done: got %b want 1", bus_a.done); end
    n_checks++; if ({bus_a.ack, bus_a.arb_lost, bus_a.busy} !== 3'b100) begin n_fail++; $display("FAIL ack50_status: got %b want 100", {bus_a.ack, bus_a.arb_lost, bus_a.busy}); end
    finish_ack();
    n_checks++; if (done_a - d0 !== 1) begin n_fail++; $display("FAIL ack50_done_count: got %0d want 1", done_a - d0); end
    n_checks++; if ({bus_a.ack, bus_a.bit_count} !== 5'b1_1000) begin n_fail++; $display("FAIL ack50_hold: got %b want 11000", {bus_a.ack, bus_a.bit_count}); end
  endtask

  task automatic test_nack_0x7f;
    int d0;
    start(7'h7F, 1'b1);
    send_bits(0, 8, -1);
    n_checks++; if (seen_a !== 8'h00) begin n_fail++; $display("FAIL nack7f_pattern: got %b want 00000000", seen_a); end
    n_checks++; if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL nack7f_early_done: got %b want 0", bus_a.done); end
    d0 = done_a;
    scl = 1'b1;
    tick();
    n_checks++; if (bus_a.done !== 1'b1) begin n_fail++; $display("FAIL nack7f_done: got %b want 1", bus_a.done); end
    n_checks++; if ({bus_a.ack, bus_a.arb_lost} !== 2'b00) begin n_fail++; $display("FAIL nack7f_status: got %b want 00", {bus_a.ack, bus_a.arb_lost}); end
    finish_ack();
    n_checks++; if (done_a - d0 !== 1) begin n_fail++; $display("FAIL nack7f_done_count: got %0d want 1", done_a - d0); end
  endtask

  task automatic test_arbitration;
    int d0, e0;
    start(7'h50, 1'b0);
    d0 = done_a;
    send_bits(0, 2, -1);
    pull_low = 1'b1;
    scl = 1'b1;
    tick();
    n_checks++; if ({bus_a.arb_lost, bus_a.done, bus_a.sda_drive_low, bus_a.ack} !== 4'b1100) begin n_fail++; $display("FAIL arb_lost_flags: got %b want 1100", {bus_a.arb_lost, bus_a.done, bus_a.sda_drive_low, bus_a.ack}); end
    n_checks++; if ({bus_b.arb_lost, bus_b.busy} !== 2'b01) begin n_fail++; $display("FAIL arb_off_running: got %b want 01", {bus_b.arb_lost, bus_b.busy}); end
    pull_low = 1'b0;
    tick();
    scl = 1'b0;
    tick();
    tick();
    send_bits(3, 8, -1);
    n_checks++; if ({bus_a.bit_count, bus_a.sda_drive_low, bus_a.busy} !== 6'b0010_00) begin n_fail++; $display("FAIL arb_no_shift: got %b want 001000", {bus_a.bit_count, bus_a.sda_drive_low, bus_a.busy}); end
    n_checks++; if (seen_b !== 8'b01011111) begin n_fail++; $display("FAIL arb_off_pattern: got %b want 01011111", seen_b); end
    n_checks++; if (bus_b.bit_count !== 4'd8) begin n_fail++; $display("FAIL arb_off_count: got %0d want 8", bus_b.bit_count); end
    e0 = done_b;
    pull_low = 1'b1;
    scl = 1'b1;
    tick();
    n_checks++; if ({bus_b.done, bus_b.ack, bus_b.arb_lost} !== 3'b110) begin n_fail++; $display("FAIL arb_off_ack: got %b want 110", {bus_b.done, bus_b.ack, bus_b.arb_lost}); end
    finish_ack();
    n_checks++; if (done_a - d0 !== 1) begin n_fail++; $display("FAIL arb_done_count: got %0d want 1", done_a - d0); end
    n_checks++; if (done_b - e0 !== 1) begin n_fail++; $display("FAIL arb_off_done_count: got %0d want 1", done_b - e0); end
    n_checks++; if ({bus_a.arb_lost, bus_a.ack} !== 2'b10) begin n_fail++; $display("FAIL arb_status_hold: got %b want 10", {bus_a.arb_lost, bus_a.ack}); end
  endtask

  task automatic test_reset_mid_byte;
    int d0;
    start(7'h50, 1'b0);
    send_bits(0, 4, -1);
    n_checks++; if (bus_a.bit_count !== 4'd4) begin n_fail++; $display("FAIL rstmid_pre_count: got %0d want 4", bus_a.bit_count); end
    d0 = done_a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if ({bus_a.sda_drive_low, bus_a.busy, bus_a.done, bus_a.ack, bus_a.arb_lost} !== 5'b00000) begin n_fail++; $display("FAIL rstmid_outputs: got %b want 00000", {bus_a.sda_drive_low, bus_a.busy, bus_a.done, bus_a.ack, bus_a.arb_lost}); end
    n_checks++; if (bus_a.bit_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", bus_a.bit_count); end
    tick();
    tick();
    n_checks++; if (done_a - d0 !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", done_a - d0); end
    start(7'h2A, 1'b1);
    n_checks++; if (bus_a.sda_drive_low !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_bit: got %b want 1", bus_a.sda_drive_low); end
    send_bits(0, 8, -1);
    n_checks++; if (seen_a !== 8'hAA) begin n_fail++; $display("FAIL rstmid_pattern: got %b want 10101010", seen_a); end
    scl = 1'b1;
    tick();
    n_checks++; if ({bus_a.done, bus_a.ack} !== 2'b10) begin n_fail++; $display("FAIL rstmid_nack: got %b want 10", {bus_a.done, bus_a.ack}); end
    finish_ack();
  endtask

  task automatic test_enable_while_busy;
    start(7'h50, 1'b0);
    send_bits(0, 2, -1);
    start(7'h11, 1'b1);
    n_checks++; if ({bus_a.busy, bus_a.bit_count, bus_a.sda_drive_low} !== 6'b1_0010_0) begin n_fail++; $display("FAIL busy_en_ignored: got %b want 100100", {bus_a.busy, bus_a.bit_count, bus_a.sda_drive_low}); end
    send_bits(2, 8, -1);
    n_checks++; if (seen_a[5:0] !== 6'b011111) begin n_fail++; $display("FAIL busy_en_pattern: got %b want 011111", seen_a[5:0]); end
    pull_low = 1'b1;
    scl = 1'b1;
    tick();
    n_checks++; if ({bus_a.done, bus_a.ack} !== 2'b11) begin n_fail++; $display("FAIL busy_en_ack: got %b want 11", {bus_a.done, bus_a.ack}); end
    finish_ack();
    start(7'h11, 1'b0);
    n_checks++; if ({bus_a.sda_drive_low, bus_a.busy, bus_a.bit_count, bus_a.ack} !== 7'b11_0000_0) begin n_fail++; $display("FAIL busy_en_accept: got %b want 1100000", {bus_a.sda_drive_low, bus_a.busy, bus_a.bit_count, bus_a.ack}); end
  endtask

  initial begin
    test_reset();
    test_ack_0x50();
    test_nack_0x7f();
    test_arbitration();
    test_reset_mid_byte();
    test_enable_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
